multdiv_iter: RTL and testbench
===============================

Name: multdiv_iter

Overview:
- Parametrised, sequential signed/unsigned multiply-divide unit for the CPU execute stage; successor to the single-cycle combinational multiplier.
- Multiply: radix-4 modified Booth, WIDTH/2 iterations. Divide: non-restoring on magnitudes, WIDTH iterations, then sign fix-up.
- Start by one-cycle ctrl pulse; completion by one-cycle data_resultRDY pulse. The pipeline stalls on the pulse.

Parameters:
- WIDTH, 32, operand/result width; even, >= 4.
- SIGNED, 1, 1 = two's-complement operands/results; 0 = unsigned.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data_operandA  in  WIDTH  multiplicand/dividend; sampled only on the start edge.
- data_operandB  in  WIDTH  multiplier/divisor; sampled only on the start edge.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  WIDTH  product low word, or quotient.
- data_result_hi  out  WIDTH  product high word, or remainder.
- data_exception  out  1  overflow or divide-by-zero; valid with the result.
- data_resultRDY  out  1  one-cycle pulse when the result is valid.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; all outputs 0; iteration counter 0.
- Start edge = rising edge with ctrl_MULT or ctrl_DIV high.
  - Operands are latched into internal registers on this edge.
  - If both are high, MULT wins and DIV is ignored.
  - A start edge in any state aborts the current operation: no RDY for the aborted op, and the new op restarts from its first iteration.
- States and transitions:
  - IDLE -> MUL on ctrl_MULT.
  - IDLE -> DIV on ctrl_DIV, except divide-by-zero, which goes directly to FIN.
  - MUL -> FIN after WIDTH/2 iteration edges.
  - DIV -> FIN after WIDTH iteration edges.
  - FIN -> IDLE after 1 edge. On this edge the results are registered and data_resultRDY is set for exactly one cycle.
- Latency, measured from start edge k:
  - RDY is high in the cycle after edge k+L.
  - MUL: L = WIDTH/2+1 (17 at WIDTH=32).
  - DIV: L = WIDTH+1 (33 at WIDTH=32).
  - Divide-by-zero: L = 1.
- busy is 1 from the cycle after the start edge through FIN, and 0 in the RDY cycle.
- data_result, data_result_hi and data_exception hold their values until the next FIN edge or reset. They are not cleared by a start.
- Multiply:
  - Booth recoding uses a 2*WIDTH+1 accumulator. SIGNED=0 extends the operands by one zero bit, plus an extra iteration pair if needed to keep WIDTH/2 exact. The implementation must keep the stated L.
  - Result = full 2*WIDTH product, split lo/hi.
  - Exception if the product does not fit in WIDTH bits:
    - SIGNED=1: hi != sign-extension of lo[WIDTH-1].
    - SIGNED=0: hi != 0.
- Divide:
  - Quotient truncates toward zero. The remainder takes the sign of the dividend (SIGNED=1).
  - B=0: result=0, result_hi=A, exception=1.
  - SIGNED=1, A=MIN, B=-1: result=MIN, result_hi=0, exception=1.
  - Otherwise exception=0.
- Operand changes after the start edge have no effect.
- ctrl pulses longer than one cycle re-trigger the operation on each edge, and only the last one completes.

Decomposition:
- Shared package multdiv_pkg holds:
  - state encoding IDLE/MUL/DIV/FIN;
  - op encoding OP_MUL/OP_DIV;
  - latency constants MUL_LAT(WIDTH) and DIV_LAT(WIDTH) for the bench and the stall logic.
- One sub-module, booth_r4_recode: combinational. Takes 3 multiplier bits and produces {0, +M, +2M, -M, -2M} as a select/negate pair.

Test Plan (WIDTH=32, SIGNED=1):
- MULT A=7, B=-3 -> RDY exactly 17 cycles after start; result=0xFFFFFFEB, hi=0xFFFFFFFF, exc=0; RDY high for 1 cycle only.
- MULT A=0x00010000, B=0x00010000 -> result=0, hi=1, exc=1. MULT A=0x80000000, B=1 -> result=0x80000000, hi=0xFFFFFFFF, exc=0.
- DIV A=-7, B=2 -> RDY at 33 cycles; result=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), exc=0.
- DIV A=5, B=0 -> RDY at 1 cycle; result=0, hi=5, exc=1. DIV A=0x80000000, B=-1 -> result=0x80000000, exc=1.
- MULT 3*4 started, then ctrl_DIV A=100, B=7 at cycle 5 -> no RDY for the MULT; a single RDY 33 cycles after the DIV start; result=14, hi=2.
- DIV started, reset_n low at cycle 8 for 2 cycles -> outputs 0 immediately (asynchronous), no RDY ever. A following MULT 6*7 gives 42 at 17 cycles.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared encodings and latency helpers for the iterative multiply/divide unit.
package multdiv_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    // Operation latched at the start edge
    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    // Booth partial-product magnitude select
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_ONE  = 2'd1,
        SEL_TWO  = 2'd2
    } booth_sel_e;

    // Edges from start edge to the edge that raises data_resultRDY
    function automatic int MUL_LAT(input int width);
        return (width / 2) + 1;
    endfunction

    function automatic int DIV_LAT(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/multdiv_iter_booth_r4_recode.sv
// Radix-4 modified Booth digit recoder: three overlapping multiplier bits
// to a {0, M, 2M} magnitude select plus a negate flag.
module booth_r4_recode
    import multdiv_pkg::*;
(
    input  logic [2:0]  i_bits,
    output booth_sel_e  o_sel,
    output logic        o_neg
);

    // Map the bit triplet onto the Booth digit {-2..+2}
    always_comb begin
        o_sel = SEL_ZERO;
        o_neg = 1'b0;
        case (i_bits)
            3'b001, 3'b010: begin o_sel = SEL_ONE; o_neg = 1'b0; end
            3'b011:         begin o_sel = SEL_TWO; o_neg = 1'b0; end
            3'b100:         begin o_sel = SEL_TWO; o_neg = 1'b1; end
            3'b101, 3'b110: begin o_sel = SEL_ONE; o_neg = 1'b1; end
            default:        begin o_sel = SEL_ZERO; o_neg = 1'b0; end
        endcase
    end

endmodule

// File: rtl/multdiv_iter.sv
// Sequential multiply/divide unit: radix-4 Booth multiply (WIDTH/2 steps),
// non-restoring magnitude divide (WIDTH steps), results registered in FIN.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_result_hi,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = WIDTH + 3;   // Booth high accumulator: |hi + 2M| < 2^(W+2)
    localparam int RW = WIDTH + 2;   // divide partial remainder, -2D < R < 2D

    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    MUL_LAST = CW'(WIDTH / 2 - 1);
    localparam logic [CW-1:0]    DIV_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [AW-1:0]    ONE_A    = {{(AW-1){1'b0}}, 1'b1};

    // Magnitude of an operand in the configured number system
    function automatic logic [WIDTH-1:0] f_abs(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) begin
            f_abs = ~v + ONE_W;
        end else begin
            f_abs = v;
        end
    endfunction

    state_e            r_state;
    state_e            w_state_nxt;
    op_e               r_op;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_opa;
    logic [WIDTH-1:0]  r_opb;
    logic [AW-1:0]     r_acc_hi;
    logic [WIDTH-1:0]  r_acc_lo;
    logic [WIDTH:0]    r_mplier;
    logic [RW-1:0]     r_rem;
    logic [WIDTH-1:0]  r_quo;
    logic [WIDTH-1:0]  r_dvs;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  r_result_hi;
    logic              r_exc;
    logic              r_rdy;
    logic              r_busy;

    logic              w_start;
    booth_sel_e        w_sel;
    logic              w_neg;
    logic [AW-1:0]     w_mcand;
    logic [AW-1:0]     w_pp_mag;
    logic [AW-1:0]     w_pp;
    logic [AW-1:0]     w_sum;
    logic [RW-1:0]     w_rem_sh;
    logic [RW-1:0]     w_rem_nxt;
    logic [WIDTH-1:0]  w_rem_fin;
    logic [WIDTH-1:0]  w_fin_lo;
    logic [WIDTH-1:0]  w_fin_hi;
    logic              w_fin_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_mcand = {{3{SIGNED & r_opa[WIDTH-1]}}, r_opa};

    booth_r4_recode u_recode (
        .i_bits (r_mplier[2:0]),
        .o_sel  (w_sel),
        .o_neg  (w_neg)
    );

    // Booth partial product and accumulator sum for one radix-4 step
    always_comb begin
        w_pp_mag = {AW{1'b0}};
        if (w_sel == SEL_ONE) begin
            w_pp_mag = w_mcand;
        end else if (w_sel == SEL_TWO) begin
            w_pp_mag = w_mcand << 1;
        end else begin
            w_pp_mag = {AW{1'b0}};
        end
        w_pp  = w_neg ? (~w_pp_mag + ONE_A) : w_pp_mag;
        w_sum = r_acc_hi + w_pp;
    end

    // One non-restoring divide step on magnitudes
    always_comb begin
        w_rem_sh = {r_rem[RW-2:0], r_quo[WIDTH-1]};
        if (r_rem[RW-1]) begin
            w_rem_nxt = w_rem_sh + {2'b00, r_dvs};
        end else begin
            w_rem_nxt = w_rem_sh - {2'b00, r_dvs};
        end
        // Final restore; modular arithmetic makes the low word exact
        if (r_rem[RW-1]) begin
            w_rem_fin = r_rem[WIDTH-1:0] + r_dvs;
        end else begin
            w_rem_fin = r_rem[WIDTH-1:0];
        end
    end

    // Result fix-up: unsigned Booth correction, divide signs and exceptions
    always_comb begin
        w_fin_lo  = ZERO_W;
        w_fin_hi  = ZERO_W;
        w_fin_exc = 1'b0;
        if (r_op == OP_MUL) begin
            w_fin_lo = r_acc_lo;
            // Booth read an unsigned B with top bit set as negative: add A*2^W
            if (!SIGNED && r_opb[WIDTH-1]) begin
                w_fin_hi = r_acc_hi[WIDTH-1:0] + r_opa;
            end else begin
                w_fin_hi = r_acc_hi[WIDTH-1:0];
            end
            if (SIGNED) begin
                w_fin_exc = (w_fin_hi != {WIDTH{w_fin_lo[WIDTH-1]}});
            end else begin
                w_fin_exc = (w_fin_hi != ZERO_W);
            end
        end else if (r_opb == ZERO_W) begin
            w_fin_lo  = ZERO_W;
            w_fin_hi  = r_opa;
            w_fin_exc = 1'b1;
        end else begin
            w_fin_lo  = (SIGNED && (r_opa[WIDTH-1] ^ r_opb[WIDTH-1])) ? (~r_quo + ONE_W) : r_quo;
            w_fin_hi  = (SIGNED && r_opa[WIDTH-1]) ? (~w_rem_fin + ONE_W) : w_rem_fin;
            // MIN / -1: magnitude quotient 2^(W-1) negates back to MIN, remainder 0
            w_fin_exc = SIGNED && (r_opa == MIN_W) && (r_opb == ONES_W);
        end
    end

    // Next-state: any start aborts and restarts, MULT has priority over DIV
    always_comb begin
        w_state_nxt = r_state;
        if (ctrl_MULT) begin
            w_state_nxt = MUL;
        end else if (ctrl_DIV) begin
            if (data_operandB == ZERO_W) begin
                w_state_nxt = FIN;
            end else begin
                w_state_nxt = DIV;
            end
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                MUL:     w_state_nxt = (r_cnt == MUL_LAST) ? FIN : MUL;
                DIV:     w_state_nxt = (r_cnt == DIV_LAST) ? FIN : DIV;
                FIN:     w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= OP_MUL;
            r_cnt    <= CNT_ZERO;
            r_opa    <= ZERO_W;
            r_opb    <= ZERO_W;
            r_acc_hi <= {AW{1'b0}};
            r_acc_lo <= ZERO_W;
            r_mplier <= {(WIDTH+1){1'b0}};
            r_rem    <= {RW{1'b0}};
            r_quo    <= ZERO_W;
            r_dvs    <= ZERO_W;
        end else if (w_start) begin
            r_op     <= ctrl_MULT ? OP_MUL : OP_DIV;
            r_cnt    <= CNT_ZERO;
            r_opa    <= data_operandA;
            r_opb    <= data_operandB;
            r_acc_hi <= {AW{1'b0}};
            r_acc_lo <= ZERO_W;
            r_mplier <= {data_operandB, 1'b0};
            r_rem    <= {RW{1'b0}};
            r_quo    <= f_abs(data_operandA);
            r_dvs    <= f_abs(data_operandB);
        end else if (r_state == MUL) begin
            r_cnt    <= r_cnt + CNT_ONE;
            r_acc_hi <= {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
            r_acc_lo <= {w_sum[1:0], r_acc_lo[WIDTH-1:2]};
            r_mplier <= {2'b00, r_mplier[WIDTH:2]};
        end else if (r_state == DIV) begin
            r_cnt    <= r_cnt + CNT_ONE;
            r_rem    <= w_rem_nxt;
            r_quo    <= {r_quo[WIDTH-2:0], ~w_rem_nxt[RW-1]};
        end else begin
            r_cnt    <= r_cnt;
        end
    end

    // Registered outputs: results and RDY on the FIN edge, busy follows next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_result    <= ZERO_W;
            r_result_hi <= ZERO_W;
            r_exc       <= 1'b0;
            r_rdy       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != IDLE);
            if ((r_state == FIN) && !w_start) begin
                r_result    <= w_fin_lo;
                r_result_hi <= w_fin_hi;
                r_exc       <= w_fin_exc;
                r_rdy       <= 1'b1;
            end else begin
                r_rdy       <= 1'b0;
            end
        end
    end

    assign data_result    = r_result;
    assign data_result_hi = r_result_hi;
    assign data_exception = r_exc;
    assign data_resultRDY = r_rdy;
    assign busy           = r_busy;

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter at WIDTH=32, SIGNED=1.
module tb_multdiv_iter;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         exc;
        int           lat;
        int           start;
    } exp_t;

    logic         clock;
    logic         reset_n;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_result;
    logic [W-1:0] data_result_hi;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    exp_t sb[$];
    exp_t last_exp;

    multdiv_iter #(.WIDTH(W), .SIGNED(1'b1)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_result_hi (data_result_hi),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Clock generation
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter, one per rising edge
    always @(posedge clock) cyc <= cyc + 1;

    // Single comparison point
    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: 64-bit signed product, SV division semantics
    function automatic exp_t model(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb_v, p;
        int     ia, ib;
        sa = longint'($signed(a));
        sb_v = longint'($signed(b));
        if (is_mul) begin
            p     = sa * sb_v;
            e.lo  = p[W-1:0];
            e.hi  = p[2*W-1:W];
            e.exc = (e.hi != {W{e.lo[W-1]}});
            e.lat = W / 2 + 1;
        end else if (b == 32'h0000_0000) begin
            e.lo = 32'h0; e.hi = a; e.exc = 1'b1; e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.lo = 32'h8000_0000; e.hi = 32'h0; e.exc = 1'b1; e.lat = W + 1;
        end else begin
            ia = $signed(a);
            ib = $signed(b);
            e.lo = ia / ib; e.hi = ia % ib; e.exc = 1'b0; e.lat = W + 1;
        end
        e.start = 0;
        return e;
    endfunction

    // Start an op on the next edge (call just after a rising edge); aborts anything pending
    task automatic issue(input bit is_mul, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        ctrl_MULT = is_mul;
        ctrl_DIV  = !is_mul;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        e = model(is_mul, a, b);
        e.start = cyc;
        sb.delete();
        sb.push_back(e);
        last_exp = e;
        @(negedge clock);
        chk_eq("busy_after_start", busy, 1);
        @(posedge clock); #1;
    endtask

    // Wait for the scoreboard to drain, bounded
    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            @(posedge clock);
        end
        #1;
        chk_eq("timeout_pending", sb.size(), 0);
    endtask

    // Output monitor: every RDY must match the head of the scoreboard
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && data_resultRDY) begin
            if (sb.size() == 0) begin
                chk_eq("rdy_unexpected", data_resultRDY, 1'b0);
            end else begin
                e = sb.pop_front();
                chk_eq("latency", cyc - e.start, e.lat);
                chk_eq("result", data_result, e.lo);
                chk_eq("result_hi", data_result_hi, e.hi);
                chk_eq("exception", data_exception, e.exc);
                chk_eq("busy_in_rdy", busy, 0);
            end
        end
    end

    // Stimulus sequence
    initial begin
        logic [W-1:0] a, b;
        reset_n = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        #1 reset_n = 1'b0;
        #1;
        chk_eq("rst_result", data_result, 0);
        chk_eq("rst_result_hi", data_result_hi, 0);
        chk_eq("rst_exc", data_exception, 0);
        chk_eq("rst_rdy", data_resultRDY, 0);
        chk_eq("rst_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        issue(1'b1, 32'd7, 32'hFFFF_FFFD);          wait_done(60);
        issue(1'b1, 32'h0001_0000, 32'h0001_0000);  wait_done(60);
        issue(1'b1, 32'h8000_0000, 32'd1);          wait_done(60);
        issue(1'b0, 32'hFFFF_FFF9, 32'd2);          wait_done(60);
        issue(1'b0, 32'd5, 32'd0);                  wait_done(60);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done(60);

        // Results hold after RDY
        repeat (3) @(posedge clock);
        #1;
        chk_eq("hold_result", data_result, last_exp.lo);
        chk_eq("hold_result_hi", data_result_hi, last_exp.hi);
        chk_eq("hold_exc", data_exception, last_exp.exc);

        // MULT aborted by a DIV started five edges later
        issue(1'b1, 32'd3, 32'd4);
        repeat (3) begin @(posedge clock); #1; end
        issue(1'b0, 32'd100, 32'd7);
        wait_done(60);
        repeat (20) @(posedge clock);
        #1;

        // Multi-cycle ctrl pulse: only the last edge completes
        ctrl_MULT = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd11;
        repeat (2) begin @(posedge clock); #1; end
        issue(1'b1, 32'hFFFF_FF00, 32'd11);
        wait_done(60);

        // Random operands, alternating ops
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = (i % 2 == 1) ? 32'($urandom_range(1, 20)) : 32'($urandom);
            if (i == 5) b = -b;
            issue(i % 2 == 0, a, b);
            wait_done(60);
        end

        // Known result, then a DIV interrupted by reset
        issue(1'b1, 32'd5, 32'd5);
        wait_done(60);
        issue(1'b0, 32'd1000, 32'd3);
        repeat (6) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        sb.delete();
        #1;
        chk_eq("arst_result", data_result, 0);
        chk_eq("arst_result_hi", data_result_hi, 0);
        chk_eq("arst_busy", busy, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        repeat (40) @(posedge clock);
        #1;
        chk_eq("post_rst_busy", busy, 0);
        chk_eq("post_rst_result", data_result, 0);
        issue(1'b1, 32'd6, 32'd7);
        wait_done(60);
        chk_eq("final_result", data_result, 42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
